mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute-stage ALU in the pipelined MIPS core.
- Consumes the ALU result (address or arithmetic value), opcode, store data and destination register.
- Runs LW/SW/LBU/SB against data memory through a req/ack handshake and stalls upstream while an access is outstanding.
- Forwards the writeback value and register controls to the writeback stage.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mem_align.sv | 39 +++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory opcodes, memory-stage FSM states and opcode helpers.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [0:0] {
        IDLE,
        ACCESS
    } mem_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data memory: store byte enables/data and load byte extraction.
module mem_align
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    always_comb begin
        be        = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;
        case (opcode)
            OP_SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            OP_SB: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            OP_LW: begin
                be        = 4'b1111;
                load_data = rdata;
            end
            OP_LBU: begin
                be        = 4'b0001 << offset;
                load_data = {24'h0, rdata[8*offset +: 8]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: runs LW/SW/LBU/SB over a req/ack data-memory port.
// Optional ack timeout with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [5:0]        in_opcode,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              bus_err
);

    mem_state_t        state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rw_q, out_rw_d;
    logic [DATA_W-1:0] load_data;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimerW-1:0] timer_q, timer_d;
    logic              bus_err_q, bus_err_d;
`endif

    mem_align u_align (
        .opcode     (op_q),
        .offset     (off_q),
        .store_data (store_q),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        store_d     = store_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_rw_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timer_d     = '0;
        bus_err_d   = bus_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && is_mem_op(in_opcode)) begin
                    state_d = ACCESS;
                    op_d    = in_opcode;
                    off_d   = in_alu_result[1:0];
                    addr_d  = {in_alu_result[DATA_W-1:2], 2'b00};
                    store_d = in_store_data;
                    rd_d    = in_rd;
                    rw_d    = in_reg_write;
                end else if (in_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_alu_result;
                    out_rd_d    = in_rd;
                    out_rw_d    = in_reg_write;
                end
            end
            ACCESS: begin
`ifdef MEM_TIMEOUT_EN
                timer_d = timer_q + TimerW'(1);
`endif
                if (dmem_ack) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    if (is_store_op(op_q)) begin
                        out_data_d = '0;
                        out_rw_d   = 1'b0;
                    end else begin
                        out_data_d = load_data;
                        out_rw_d   = rw_q;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                // Give up on the access and hand writeback a harmless no-op result.
                else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_rd_d    = rd_q;
                    out_rw_d    = 1'b0;
                    bus_err_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            store_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_rw_q    <= out_rw_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign stall         = (state_q == ACCESS) || (in_valid && is_mem_op(in_opcode));
    assign dmem_req      = (state_q == ACCESS);
    assign dmem_we       = (state_q == ACCESS) && is_store_op(op_q);
    assign dmem_addr     = addr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_rw_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic vs a transaction model.
module tb_mem_stage;

    localparam int unsigned TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LBU = 6'b100100, SB = 6'b101000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_opcode;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_reg_write, bus_err;

    int total = 0;
    int bad = 0;

    // Transaction-level model state
    bit          m_busy, m_ov, m_orw, m_berr, m_chk_data;
    logic [5:0]  m_op;
    logic [31:0] m_addr, m_sdata, m_rdata, m_od;
    logic [4:0]  m_rd, m_ord;
    bit          m_rw;
    int          m_wait, m_lat;

    int          f_lat = -1;
    logic [31:0] f_rdata;
    bit          f_ack_once = 1'b0;
    bit          rnd_mode = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_opcode     (in_opcode),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .bus_err       (bus_err)
    );

    function automatic bit is_mem(input logic [5:0] op);
        return op == LW || op == SW || op == LBU || op == SB;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at negedge, answer the memory, advance the model, return at posedge+1.
    task automatic cycle();
        int off;
        @(negedge clk);
        chk("stall", {31'b0, stall}, {31'b0, m_busy || (in_valid && is_mem(in_opcode))});
        chk("req", {31'b0, dmem_req}, {31'b0, m_busy});
        chk("we", {31'b0, dmem_we}, {31'b0, m_busy && (m_op == SW || m_op == SB)});
        if (m_busy) begin
            off = int'(m_addr % 4);
            chk("addr", dmem_addr, m_addr - (m_addr % 4));
            if (m_op == SW) begin
                chk("be_sw", {28'b0, dmem_be}, 32'hF);
                chk("wdata_sw", dmem_wdata, m_sdata);
            end else if (m_op == SB) begin
                chk("be_sb", {28'b0, dmem_be}, 32'(1 << off));
                chk("wdata_sb", dmem_wdata, (m_sdata & 32'hFF) * 32'h0101_0101);
            end else if (m_op == LW) begin
                chk("be_lw", {28'b0, dmem_be}, 32'hF);
            end
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("out_reg_write", {31'b0, out_reg_write}, {31'b0, m_orw});
        chk("bus_err", {31'b0, bus_err}, {31'b0, m_berr});
        if (m_ov && m_orw) chk("out_rd", {27'b0, out_rd}, {27'b0, m_ord});
        if (m_ov && m_chk_data) chk("out_data", out_data, m_od);

        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (m_busy && m_wait == m_lat) begin
            dmem_ack   = 1'b1;
            dmem_rdata = m_rdata;
        end else if (!m_busy && (f_ack_once || (rnd_mode && $urandom_range(0, 3) == 0))) begin
            dmem_ack = 1'b1;
        end
        f_ack_once = 1'b0;

        if (rst) begin
            m_busy = 0; m_ov = 0; m_orw = 0; m_berr = 0; m_od = 0; m_ord = 0; m_chk_data = 1;
        end else if (m_busy) begin
            off = int'(m_addr % 4);
            if (dmem_ack) begin
                m_busy = 0; m_ov = 1; m_ord = m_rd;
                if (m_op == LW) begin
                    m_od = dmem_rdata; m_orw = m_rw; m_chk_data = 1;
                end else if (m_op == LBU) begin
                    m_od = (dmem_rdata >> (8 * off)) & 32'hFF; m_orw = m_rw; m_chk_data = 1;
                end else begin
                    m_orw = 0; m_chk_data = 0;
                end
            end else if (TO_EN && m_wait == TO - 1) begin
                m_busy = 0; m_ov = 1; m_od = 0; m_orw = 0; m_berr = 1; m_chk_data = 1;
            end else begin
                m_wait++; m_ov = 0; m_orw = 0;
            end
        end else if (in_valid && is_mem(in_opcode)) begin
            m_busy = 1; m_op = in_opcode; m_addr = in_alu_result; m_sdata = in_store_data;
            m_rd = in_rd; m_rw = in_reg_write; m_wait = 0;
            m_lat   = (f_lat >= 0) ? f_lat : $urandom_range(0, 5);
            m_rdata = (f_lat >= 0) ? f_rdata : $urandom;
            m_ov = 0; m_orw = 0;
        end else if (in_valid) begin
            m_ov = 1; m_od = in_alu_result; m_ord = in_rd; m_orw = in_reg_write; m_chk_data = 1;
        end else begin
            m_ov = 0; m_orw = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        in_valid = 1'b1; in_opcode = op; in_alu_result = alu; in_store_data = sd;
        in_rd = rd; in_reg_write = rw;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_opcode = 0; in_alu_result = 0; in_store_data = 0;
        in_rd = 0; in_reg_write = 0; dmem_ack = 0; dmem_rdata = 0;
        m_busy = 0; m_ov = 0; m_orw = 0; m_berr = 0; m_od = 0; m_ord = 0; m_chk_data = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_we", {31'b0, dmem_we}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_be", {28'b0, dmem_be}, 32'h0);
        chk("rst_ov", {31'b0, out_valid}, 32'h0);
        chk("rst_od", out_data, 32'h0);
        chk("rst_ord", {27'b0, out_rd}, 32'h0);
        chk("rst_orw", {31'b0, out_reg_write}, 32'h0);
        chk("rst_berr", {31'b0, bus_err}, 32'h0);
        rst = 1'b0;

        // ADDU
        drive(6'b000000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        #1 chk("addu_stall", {31'b0, stall}, 32'h0);
        cycle();
        in_valid = 0;
        chk("addu_ov", {31'b0, out_valid}, 32'h1);
        chk("addu_od", out_data, 32'h1234);
        chk("addu_rd", {27'b0, out_rd}, 32'd5);

        // LW with ack in the third access cycle
        f_lat = 2; f_rdata = 32'hDEAD_BEEF;
        drive(LW, 32'h100, 32'h0, 5'd7, 1'b1);
        #1 chk("lw_stall_issue", {31'b0, stall}, 32'h1);
        cycle();
        in_valid = 0;
        chk("lw_req", {31'b0, dmem_req}, 32'h1);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_be", {28'b0, dmem_be}, 32'hF);
        chk("lw_we", {31'b0, dmem_we}, 32'h0);
        repeat (3) cycle();
        chk("lw_ov", {31'b0, out_valid}, 32'h1);
        chk("lw_od", out_data, 32'hDEAD_BEEF);
        chk("lw_req_drop", {31'b0, dmem_req}, 32'h0);

        // SB to byte 3
        f_lat = 0;
        drive(SB, 32'h203, 32'h0000_00A5, 5'd3, 1'b1);
        cycle();
        in_valid = 0;
        chk("sb_be", {28'b0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'b0, dmem_we}, 32'h1);
        cycle();
        chk("sb_ov", {31'b0, out_valid}, 32'h1);
        chk("sb_orw", {31'b0, out_reg_write}, 32'h0);

        // LBU from byte 2
        f_lat = 1; f_rdata = 32'h11FF_2233;
        drive(LBU, 32'h302, 32'h0, 5'd9, 1'b1);
        cycle();
        in_valid = 0;
        repeat (2) cycle();
        chk("lbu_od", out_data, 32'h0000_00FF);
        chk("lbu_orw", {31'b0, out_reg_write}, 32'h1);

        // Reset in the second access cycle, then a late ack
        f_lat = 10;
        drive(LW, 32'h400, 32'h0, 5'd4, 1'b1);
        cycle();
        in_valid = 0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstmid_req", {31'b0, dmem_req}, 32'h0);
        chk("rstmid_ov", {31'b0, out_valid}, 32'h0);
        f_ack_once = 1'b1;
        cycle();
        chk("late_ack_ov", {31'b0, out_valid}, 32'h0);
        chk("late_ack_req", {31'b0, dmem_req}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        f_lat = 100;
        drive(LW, 32'h500, 32'h0, 5'd6, 1'b1);
        cycle();
        in_valid = 0;
        repeat (3) cycle();
        chk("to_req_held", {31'b0, dmem_req}, 32'h1);
        cycle();
        chk("to_req", {31'b0, dmem_req}, 32'h0);
        chk("to_berr", {31'b0, bus_err}, 32'h1);
        chk("to_ov", {31'b0, out_valid}, 32'h1);
        chk("to_od", out_data, 32'h0);
        chk("to_orw", {31'b0, out_reg_write}, 32'h0);
        cycle();
        chk("to_berr_sticky", {31'b0, bus_err}, 32'h1);
`endif

        // Randomized traffic
        f_lat = -1;
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_opcode     = (sel == 0) ? LW : (sel == 1) ? SW : (sel == 2) ? LBU :
                            (sel == 3) ? SB : (sel == 4) ? 6'b000000 : 6'($urandom_range(0, 63));
            in_alu_result = $urandom;
            in_store_data = $urandom;
            in_rd         = 5'($urandom_range(0, 31));
            in_reg_write  = 1'($urandom_range(0, 1));
            rst           = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
